seg_scan_ctrl: RTL and testbench

//   Time-multiplexes the 4-digit common-anode 7-segment display: steps an/seg through digits 0..3.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/hex_to_seg7.sv | 11 +
 rtl/seg_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: blanking patterns,
// hex-to-segment table (active-low {g,f,e,d,c,b,a}) and FSM state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Entry i holds the pattern for hex digit i (index 15 listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern decode.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  always_comb seg_c = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scanner with anti-ghost gaps, frame-aligned
// value commits and optional leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned GAP_CYCLES   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        lzb,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done,
  output logic        upd_done
);

  localparam int unsigned MAX_CYC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       digit, digit_n;
  logic [15:0]      disp_reg, pend_reg;
  logic             pend_flag;
  logic [3:0]       an_n;
  logic [6:0]       seg_n;
  logic             frame_n, upd_n;
  logic             commit_c;
  logic [3:0]       nibble_c;
  logic [15:0]      upper_c;
  logic             blank_c;
  logic [6:0]       dec_seg_c;

  // Current digit's nibble and whether it falls in the leading-zero run.
  always_comb begin
    nibble_c = disp_reg[{digit, 2'b00} +: 4];
    upper_c  = disp_reg >> {digit, 2'b00};
    blank_c  = lzb && (digit != 2'd0) && (upper_c == 16'h0000);
  end

  hex_to_seg7 u_dec (
    .hex   (nibble_c),
    .seg_c (dec_seg_c)
  );

  // Next-state and next-output logic; digit is already the upcoming one during GAP.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CNT_W'(1);
    digit_n  = digit;
    an_n     = AN_OFF;
    seg_n    = SEG_BLANK;
    frame_n  = 1'b0;
    upd_n    = 1'b0;
    commit_c = 1'b0;
    case (state)
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = ST_ON;
          cnt_n   = '0;
        end
      end
      ST_ON: begin
        if (cnt == DWELL_LAST) begin
          state_n = ST_GAP;
          cnt_n   = '0;
          digit_n = digit + 2'd1;
          if (digit == 2'd3) begin
            commit_c = 1'b1;
            frame_n  = 1'b1;
            upd_n    = pend_flag;
          end
        end
      end
      default: begin
        state_n = ST_GAP;
        cnt_n   = '0;
      end
    endcase
    if (state_n == ST_ON && !blank_c) begin
      an_n  = ~(4'b0001 << digit);
      seg_n = dec_seg_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_GAP;
      cnt        <= '0;
      digit      <= 2'd0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
      upd_done   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit      <= digit_n;
      an         <= an_n;
      seg        <= seg_n;
      frame_done <= frame_n;
      upd_done   <= upd_n;
    end
  end

  // A load on the commit edge is kept pending; the commit takes the older value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_reg  <= 16'h0000;
      pend_reg  <= 16'h0000;
      pend_flag <= 1'b0;
    end else begin
      if (commit_c && pend_flag) begin
        disp_reg <= pend_reg;
      end
      if (load) begin
        pend_reg  <= value;
        pend_flag <= 1'b1;
      end else if (commit_c) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DWELL_CYCLES=4, GAP_CYCLES=2 (24-cycle frame).
module tb_seg_scan_ctrl;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110, SF = 7'b0001110;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        lzb = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done, upd_done;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(.DWELL_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .lzb(lzb),
    .an(an), .seg(seg), .frame_done(frame_done), .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             lzb;
    int               l1p;
    logic [15:0]      l1v;
    int               l2p;
    logic [15:0]      l2v;
    logic [3:0]       en0;
    logic [3:0][6:0]  segs1;
    logic [3:0]       en1;
    logic             ud1;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string tag, input int pos, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s pos=%0d got an=%b seg=%b fd=%b ud=%b want an=%b seg=%b fd=%b ud=%b",
               tag, pos, got[12:9], got[8:2], got[1], got[0], exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  // Walks frame positions 0..npos-1, checking each cycle and driving up to two loads.
  task automatic run_frame(input string tag, input logic [3:0][6:0] segs, input logic [3:0] en,
                           input logic fd0, input logic ud0, input int l1p, input logic [15:0] l1v,
                           input int l2p, input logic [15:0] l2v, input int npos);
    logic [3:0]  one;
    logic [12:0] exp;
    one = 4'b0001;
    for (int p = 0; p < npos; p++) begin
      int d;
      int q;
      d = p / 6;
      q = p % 6;
      exp = {4'b1111, B, 1'b0, 1'b0};
      if (q >= 2 && en[d]) exp[12:2] = {~(one << d), segs[d]};
      if (p == 0) exp[1:0] = {fd0, ud0};
      check(tag, p, {an, seg, frame_done, upd_done}, exp);
      load  = 1'b0;
      value = 16'h0000;
      if (p == l1p) begin load = 1'b1; value = l1v; end
      if (p == l2p) begin load = 1'b1; value = l2v; end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic do_reset(input logic lz);
    load  = 1'b0;
    lzb   = lz;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_hold", 0, {an, seg, frame_done, upd_done}, {4'b1111, B, 2'b00});
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0][6:0] zeros;
    zeros = {S0, S0, S0, S0};

    vecs[0] = '{"no_load",  1'b0, -1, 16'h0000, -1, 16'h0000, 4'b1111, {S0, S0, S0, S0}, 4'b1111, 1'b0};
    vecs[1] = '{"ld_12AF",  1'b0,  5, 16'h12AF, -1, 16'h0000, 4'b1111, {S1, S2, SA, SF}, 4'b1111, 1'b1};
    vecs[2] = '{"ld_latest",1'b0,  3, 16'h1111,  9, 16'h2222, 4'b1111, {S2, S2, S2, S2}, 4'b1111, 1'b1};
    vecs[3] = '{"lzb_0050", 1'b1,  5, 16'h0050, -1, 16'h0000, 4'b0001, {S0, S0, S5, S0}, 4'b0011, 1'b1};
    vecs[4] = '{"lzb_0000", 1'b1,  5, 16'h0000, -1, 16'h0000, 4'b0001, {S0, S0, S0, S0}, 4'b0001, 1'b1};
    vecs[5] = '{"lzb_0F00", 1'b1,  7, 16'h0F00, -1, 16'h0000, 4'b0001, {S0, SF, S0, S0}, 4'b0111, 1'b1};
    vecs[6] = '{"hex_8E3C", 1'b0, 22, 16'h8E3C, -1, 16'h0000, 4'b1111, {S8, SE, S3, SC}, 4'b1111, 1'b1};
    vecs[7] = '{"hex_9B45", 1'b1,  0, 16'h9B45, -1, 16'h0000, 4'b0001, {S9, SB, S4, S5}, 4'b1111, 1'b1};
    vecs[8] = '{"hex_76D0", 1'b0, 12, 16'h76D0, -1, 16'h0000, 4'b1111, {S7, S6, SD, S0}, 4'b1111, 1'b1};

    @(negedge clk);
    check("reset_init", 0, {an, seg, frame_done, upd_done}, {4'b1111, B, 2'b00});

    for (int i = 0; i < 9; i++) begin
      do_reset(vecs[i].lzb);
      run_frame({vecs[i].name, "_f0"}, zeros, vecs[i].en0, 1'b0, 1'b0,
                vecs[i].l1p, vecs[i].l1v, vecs[i].l2p, vecs[i].l2v, 24);
      run_frame({vecs[i].name, "_f1"}, vecs[i].segs1, vecs[i].en1, 1'b1, vecs[i].ud1,
                -1, 16'h0, -1, 16'h0, 24);
      run_frame({vecs[i].name, "_f2"}, vecs[i].segs1, vecs[i].en1, 1'b1, 1'b0,
                -1, 16'h0, -1, 16'h0, 6);
    end

    // Load landing on the commit cycle waits one more frame.
    do_reset(1'b0);
    run_frame("coinc_f0", zeros, 4'b1111, 1'b0, 1'b0, 5, 16'hAAAA, 23, 16'hBBBB, 24);
    run_frame("coinc_f1", {SA, SA, SA, SA}, 4'b1111, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0, 24);
    run_frame("coinc_f2", {SB, SB, SB, SB}, 4'b1111, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0, 24);
    run_frame("coinc_f3", {SB, SB, SB, SB}, 4'b1111, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0, 6);

    // Async reset during digit-2 ON drops display and pending value.
    do_reset(1'b0);
    run_frame("rst_f0", zeros, 4'b1111, 1'b0, 1'b0, 5, 16'h12AF, -1, 16'h0, 24);
    run_frame("rst_f1", {S1, S2, SA, SF}, 4'b1111, 1'b1, 1'b1, 3, 16'h3333, -1, 16'h0, 15);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", 15, {an, seg, frame_done, upd_done}, {4'b1111, B, 2'b00});
    @(negedge clk);
    reset = 1'b0;
    run_frame("rst_after0", zeros, 4'b1111, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, 24);
    run_frame("rst_after1", zeros, 4'b1111, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
